// File: rtl/stopwatch_bcd.sv
// BCD stopwatch mm:ss.cc with pause, lap/split display and overflow flag.
// Commands are one-cycle pulses; priority clear > start_stop > lap.
module stopwatch_bcd #(
  parameter int TICK_DIV = 500000,
  parameter int PRESC_W  = 19,
  parameter bit WRAP     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LAP
  } state_t;

  localparam logic [PRESC_W-1:0] TICK_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [23:0]        CNT_MAX  = 24'h595999;

  state_t             r_state;
  state_t             w_state_nx;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_nx;
  logic [23:0]        r_cnt;
  logic [23:0]        r_lap;
  logic               r_ovf;
  logic [23:0]        w_cnt_inc;
  logic [23:0]        w_cnt_nx;
  logic               w_en;
  logic               w_tick;
  logic               w_clr;
  logic               w_ss;
  logic               w_lap;
  logic               w_max;
  logic               w_halt;

  assign w_en   = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick = w_en && (r_presc == TICK_MAX);
  assign w_clr  = clear &&
                  ((r_state == S_IDLE) || (r_state == S_PAUSE));
  assign w_ss   = start_stop && !clear;
  assign w_lap  = lap && !clear && !start_stop && w_en;
  assign w_max  = (r_cnt == CNT_MAX);
  assign w_halt = w_tick && w_max && !WRAP;

  // BCD increment with the whole carry chain rippled in one cycle
  always_comb begin : p_inc
    logic       v_c;
    logic [3:0] v_lim;
    w_cnt_inc = r_cnt;
    v_c       = 1'b1;
    v_lim     = 4'd9;
    for (int i = 0; i < 6; i++) begin
      v_lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      if (v_c) begin
        if (r_cnt[i*4 +: 4] == v_lim) begin
          w_cnt_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_cnt_inc[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'd1;
          v_c = 1'b0;
        end
      end
    end
  end

  // next live count and prescaler value
  always_comb begin
    w_cnt_nx   = r_cnt;
    w_presc_nx = r_presc;
    if (w_tick && !w_halt) begin
      w_cnt_nx = w_cnt_inc;
    end
    if (w_en) begin
      w_presc_nx = w_tick ? '0 : r_presc + PRESC_W'(1);
    end else if (r_state == S_IDLE) begin
      w_presc_nx = '0;
    end
  end

  // FSM next state; saturating overflow forces a pause
  always_comb begin
    w_state_nx = r_state;
    unique case (1'b1)
      w_clr: w_state_nx = S_IDLE;
      w_ss: begin
        if (w_en) w_state_nx = S_PAUSE;
        else      w_state_nx = S_RUN;
      end
      w_lap:   w_state_nx = S_LAP;
      default: w_state_nx = r_state;
    endcase
    if (w_halt) begin
      w_state_nx = S_PAUSE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // datapath registers: prescaler, live count, lap, overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_lap   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clr) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_lap   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_presc <= w_presc_nx;
      r_cnt   <= w_cnt_nx;
      if (w_lap) r_lap <= w_cnt_nx;
      if (w_tick && w_max) r_ovf <= 1'b1;
    end
  end

  assign disp       = (r_state == S_LAP) ? r_lap : r_cnt;
  assign running    = w_en;
  assign lap_active = (r_state == S_LAP);
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: centisecond-integer reference model,
// random and directed commands, plus two TICK_DIV=1 overflow instances.
module tb_stopwatch_bcd;

  localparam int TD      = 4;
  localparam int MAXCS   = 359999;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ss, cl, lp;
  logic [23:0] disp;
  logic        run, lact, ovf;

  logic        rst_o, ss_o, clr_o;
  logic [23:0] d1, d0;
  logic        r1, r0, la1, la0, o1, o0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [26:0] q[$];

  int m_st, m_cs, m_lap, m_pre;
  bit m_ovf;

  stopwatch_bcd #(.TICK_DIV(TD), .PRESC_W(2), .WRAP(1'b1)) dut (
    .clk(clk), .reset(rst_n), .start_stop(ss), .clear(cl), .lap(lp),
    .disp(disp), .running(run), .lap_active(lact), .ovf(ovf)
  );

  stopwatch_bcd #(.TICK_DIV(1), .PRESC_W(1), .WRAP(1'b1)) u_w1 (
    .clk(clk), .reset(rst_o), .start_stop(ss_o), .clear(clr_o),
    .lap(1'b0), .disp(d1), .running(r1), .lap_active(la1), .ovf(o1)
  );

  stopwatch_bcd #(.TICK_DIV(1), .PRESC_W(1), .WRAP(1'b0)) u_w0 (
    .clk(clk), .reset(rst_o), .start_stop(ss_o), .clear(clr_o),
    .lap(1'b0), .disp(d0), .running(r0), .lap_active(la0), .ovf(o0)
  );

  task automatic chk(string nm, logic [23:0] act, logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] bcd(int v);
    int m, s, c;
    m = v / 6000;
    s = (v / 100) % 60;
    c = v % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_rst();
    m_st  = S_IDLE;
    m_cs  = 0;
    m_lap = 0;
    m_pre = 0;
    m_ovf = 1'b0;
  endtask

  task automatic step(bit c, bit s, bit l);
    bit en, tick;
    logic [23:0] ed;
    @(negedge clk);
    cl = c;
    ss = s;
    lp = l;
    en   = (m_st == S_RUN) || (m_st == S_LAP);
    tick = en && (m_pre == TD - 1);
    if (en) begin
      if (tick) begin
        m_pre = 0;
        if (m_cs == MAXCS) begin
          m_ovf = 1'b1;
          m_cs  = 0;
        end else begin
          m_cs++;
        end
      end else begin
        m_pre++;
      end
    end
    if (c) begin
      if (m_st == S_IDLE || m_st == S_PAUSE) begin
        model_rst();
      end
    end else if (s) begin
      m_st = en ? S_PAUSE : S_RUN;
    end else if (l && en) begin
      m_st  = S_LAP;
      m_lap = m_cs;
    end
    ed = (m_st == S_LAP) ? bcd(m_lap) : bcd(m_cs);
    q.push_back({ed, (m_st == S_RUN || m_st == S_LAP),
                 (m_st == S_LAP), m_ovf});
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // monitor: one expected entry per clocked cycle of stimulus
  initial begin
    logic [26:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({disp, run, lact, ovf} !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got disp=%h run=%b lap=%b ovf=%b want disp=%h run=%b lap=%b ovf=%b",
                   $time, disp, run, lact, ovf,
                   e[26:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic main_seq();
    int r;
    rst_n = 1'b1; ss = 0; cl = 0; lp = 0;
    model_rst();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_disp", disp, 24'h0);
    chk("rst_run", 24'(run), 24'h0);
    chk("rst_lap", 24'(lact), 24'h0);
    chk("rst_ovf", 24'(ovf), 24'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(0, 1, 0);
    repeat (400) step(0, 0, 0);
    settle();
    chk("run400_disp", disp, 24'h000100);
    chk("run400_run", 24'(run), 24'h1);

    step(0, 1, 0);
    step(1, 0, 0);
    settle();
    chk("clr_pause_disp", disp, 24'h0);

    step(0, 1, 0);
    repeat (149) step(0, 0, 0);
    step(0, 1, 0);
    repeat (50) step(0, 0, 0);
    settle();
    chk("pause_disp", disp, 24'h000037);
    chk("pause_run", 24'(run), 24'h0);
    step(0, 1, 0);
    step(0, 0, 0);
    settle();
    chk("resume_1", disp, 24'h000037);
    step(0, 0, 0);
    settle();
    chk("resume_2", disp, 24'h000038);

    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (148) step(0, 0, 0);
    step(0, 0, 1);
    repeat (40) step(0, 0, 0);
    settle();
    chk("lap_disp", disp, 24'h000037);
    chk("lap_act", 24'(lact), 24'h1);
    step(0, 1, 0);
    settle();
    chk("lap_pause_disp", disp, 24'h000047);
    chk("lap_pause_act", 24'(lact), 24'h0);

    step(1, 1, 0);
    settle();
    chk("clr_ss_disp", disp, 24'h0);
    chk("clr_ss_run", 24'(run), 24'h0);

    step(0, 1, 0);
    repeat (20) step(0, 0, 0);
    step(1, 0, 0);
    settle();
    chk("clr_run_run", 24'(run), 24'h1);
    chk("clr_run_disp", disp, 24'h000005);

    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      step((r < 4) || (r == 99),
           (r >= 4 && r < 9) || (r == 99) || (r == 98),
           (r >= 9 && r < 14) || (r == 98));
    end

    for (int k = 0; k < 4 && m_st != S_LAP; k++) begin
      if (m_st == S_RUN) step(0, 0, 1);
      else               step(0, 1, 0);
    end
    repeat (10) step(0, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_lap", 24'(lact), 24'h1);
    rst_n = 1'b0;
    #1;
    chk("async_disp", disp, 24'h0);
    chk("async_run", 24'(run), 24'h0);
    chk("async_lap", 24'(lact), 24'h0);
    chk("async_ovf", 24'(ovf), 24'h0);
    @(negedge clk);
    ss = 1'b1;
    lp = 1'b1;
    settle();
    chk("rst_hold_disp", disp, 24'h0);
    chk("rst_hold_run", 24'(run), 24'h0);
    @(negedge clk);
    ss = 1'b0;
    lp = 1'b0;
    rst_n = 1'b1;
    model_rst();

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      step(r < 4, r >= 4 && r < 10, r >= 10 && r < 15);
    end
    step(0, 0, 0);
    settle();
    #1;
    chk("queue_drained", 24'(q.size()), 24'h0);
  endtask

  task automatic ovf_seq();
    rst_o = 1'b1; ss_o = 0; clr_o = 0;
    #1 rst_o = 1'b0;
    repeat (2) @(negedge clk);
    rst_o = 1'b1;
    @(negedge clk);
    ss_o = 1'b1;
    @(negedge clk);
    ss_o = 1'b0;
    repeat (MAXCS) @(posedge clk);
    #1;
    chk("w1_max_disp", d1, 24'h595999);
    chk("w1_max_ovf", 24'(o1), 24'h0);
    chk("w0_max_disp", d0, 24'h595999);
    @(posedge clk);
    #1;
    chk("w1_wrap_disp", d1, 24'h0);
    chk("w1_wrap_ovf", 24'(o1), 24'h1);
    chk("w1_wrap_run", 24'(r1), 24'h1);
    chk("w0_sat_disp", d0, 24'h595999);
    chk("w0_sat_ovf", 24'(o0), 24'h1);
    chk("w0_sat_run", 24'(r0), 24'h0);
    @(negedge clk);
    clr_o = 1'b1;
    settle();
    chk("w0_clr_disp", d0, 24'h0);
    chk("w0_clr_ovf", 24'(o0), 24'h0);
    chk("w1_clr_ign_ovf", 24'(o1), 24'h1);
    chk("w1_clr_ign_run", 24'(r1), 24'h1);
    chk("w1_clr_ign_disp", d1, 24'h000001);
    @(negedge clk);
    clr_o = 1'b0;
  endtask

  initial begin
    fork
      main_seq();
      ovf_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 The block SHALL expose parameter TICK_DIV, default 500000, giving clk cycles per 0.01 s tick (legal range >= 1).
REQ-002 The block SHALL expose parameter PRESC_W, default 19, giving prescaler width (2^PRESC_W >= TICK_DIV).
REQ-003 The block SHALL expose parameter WRAP, default 1, where 1 = wrap to zero on overflow and 0 = saturate and pause.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start_stop  input  1  synchronous one-cycle command pulse: start, pause or resume.
REQ-007 clear  input  1  synchronous one-cycle command pulse: return to zero.
REQ-008 lap  input  1  synchronous one-cycle command pulse: capture or refresh split time.
REQ-009 disp  output  24  BCD display {m1,m0,s1,s0,c1,c0}: minutes, seconds, centiseconds.
REQ-010 running  output  1  high in RUN and LAP.
REQ-011 lap_active  output  1  high in LAP.
REQ-012 ovf  output  1  sticky flag, set on roll past 59:59.99.

Function
REQ-013 Each input held high for N cycles SHALL act as N separate commands; edge detection is upstream.
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE and LAP.
REQ-015 FSM transitions SHALL be:
- IDLE + start_stop -> RUN
- RUN + start_stop -> PAUSE
- PAUSE + start_stop -> RUN
- LAP + start_stop -> PAUSE
REQ-016 lap SHALL behave as follows:
- RUN + lap -> LAP and capture the live count.
- LAP + lap -> stay in LAP and recapture the live count.
- lap in IDLE or PAUSE is ignored.
REQ-017 clear SHALL behave as follows:
- In IDLE or PAUSE: go to IDLE; zero the live count, lap register, prescaler and ovf.
- In RUN or LAP: ignored.
REQ-018 Same-cycle commands SHALL be prioritised clear > start_stop > lap; the lower-priority command in that cycle is dropped.
REQ-019 Prescaler behaviour:
- Counts only in RUN or LAP.
- Holds its value in PAUSE.
- Is 0 in IDLE.
- On reaching TICK_DIV-1, asserts tick and returns to 0 on the same edge.
REQ-020 With TICK_DIV=1, tick SHALL assert every cycle spent in RUN or LAP.
REQ-021 The first tick after IDLE->RUN SHALL occur on the TICK_DIV-th edge after the edge that sampled start_stop.
REQ-022 On tick, the live count SHALL increment with the full BCD carry chain resolved on that same edge:
- c0, c1, s0 and m0 roll 9->0.
- s1 and m1 roll 5->0.
- No digit ever holds a value above 9 (tens digits above 5).
REQ-023 Overflow (tick at 59:59.99) with WRAP=1 SHALL set the live count to 00:00.00, set ovf, and keep the state unchanged.
REQ-024 Overflow with WRAP=0 SHALL hold the count at 59:59.99, set ovf, and move RUN or LAP to PAUSE.
REQ-025 ovf SHALL clear only on clear or reset.
REQ-026 disp SHALL show the lap register in LAP and the live count in every other state.
REQ-027 disp SHALL be a registered or mux-of-registers output with zero added latency: it reflects the count registers updated on the same edge.
REQ-028 In LAP, the live count SHALL continue incrementing invisibly; leaving LAP SHALL show the live value on the next cycle.
REQ-029 Capture on lap SHALL take the live value after that edge's increment, if a tick coincides with the lap pulse.

Reset
REQ-030 When reset is low, the block SHALL immediately, without waiting for clk:
- set FSM = IDLE, prescaler = 0, live count = 0, lap register = 0
- set disp = 24'h000000, running = 0, lap_active = 0, ovf = 0
REQ-031 Reset SHALL override every command, including mid-run and mid-lap.
REQ-032 After reset deasserts, the block SHALL ignore commands until the first rising clk edge.

Verification (TICK_DIV=4 unless stated)
REQ-033 start_stop, then 400 cycles -> disp = 24'h000100, running = 1.
REQ-034 start_stop at 00:00.37 plus 2 prescaler cycles, wait 50 cycles, start_stop -> disp stays 24'h000037 during pause; next tick lands exactly 2 cycles after resume.
REQ-035 lap at disp 24'h000037, run 40 more cycles -> disp = 24'h000037, lap_active = 1; then start_stop -> PAUSE, disp = 24'h000047.
REQ-036 TICK_DIV=1, WRAP=1, 360000 cycles in RUN -> disp goes 24'h595999 to 24'h000000, ovf = 1, running = 1.
REQ-037 TICK_DIV=1, WRAP=0, same run -> disp holds 24'h595999, ovf = 1, running = 0; then clear -> disp = 0, ovf = 0.
REQ-038 Each of the following SHALL be checked:
- reset low mid-LAP -> all outputs 0 asynchronously.
- clear + start_stop in the same cycle in PAUSE -> IDLE, disp = 0, running = 0.
- clear during RUN -> ignored.
